// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and the one-hot master state encoding.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam int S_IDLE    = 0;
    localparam int S_WR_ADDR = 1;
    localparam int S_WR_DATA = 2;
    localparam int S_WR_RESP = 3;
    localparam int S_RD_ADDR = 4;
    localparam int S_RD_DATA = 5;
    localparam int S_RSP     = 6;

    typedef enum logic [6:0] {
        ST_IDLE    = 7'b0000001,
        ST_WR_ADDR = 7'b0000010,
        ST_WR_DATA = 7'b0000100,
        ST_WR_RESP = 7'b0001000,
        ST_RD_ADDR = 7'b0010000,
        ST_RD_DATA = 7'b0100000,
        ST_RSP     = 7'b1000000
    } master_state_t;

endpackage

// File: rtl/axi_bus.sv
// AXI4-Lite channel bundle between the master and axi4_lite_ram.
interface AXI_BUS #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic                  aw_valid;
    logic                  aw_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_valid;
    logic                  w_ready;
    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  b_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_valid;
    logic                  r_ready;

    modport Master (
        output aw_addr, aw_valid, input aw_ready,
        output w_data, w_valid, input w_ready,
        input b_resp, b_valid, output b_ready,
        output ar_addr, ar_valid, input ar_ready,
        input r_data, r_resp, r_valid, output r_ready
    );

    modport Slave (
        input aw_addr, aw_valid, output aw_ready,
        input w_data, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input ar_addr, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );
endinterface

// File: rtl/axi4_lite_timeout.sv
// Saturating watchdog: counts busy cycles since the last state change and
// raises a sticky flag once the count reaches TIMEOUT_CYCLES-1.
module axi4_lite_timeout #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy_i,
    input  logic restart_i,
    output logic timeout_o
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          flag_q, flag_d;

    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (busy_i && (cnt_q == LIMIT)) begin
            flag_d = 1'b1;
        end
        if (restart_i) begin
            cnt_d = '0;
        end else if (busy_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign timeout_o = flag_q;
endmodule

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: one request becomes one AW/W/B or AR/R sequence.
// Valids and payloads are held until their ready; req_ready stays low until the response is taken.
// AXI_MASTER_TIMEOUT_EN adds a sticky watchdog flag on the timeout port.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    AXI_BUS.Master                amba_master
`ifdef AXI_MASTER_TIMEOUT_EN
    ,
    output logic                  timeout
`endif
);
    master_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  write_q, write_d;
    resp_t                 resp_q, resp_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        write_d = write_q;
        resp_d  = resp_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    state_d = req_write ? ST_WR_ADDR : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR: if (amba_master.aw_ready) state_d = ST_WR_DATA;
            ST_WR_DATA: if (amba_master.w_ready)  state_d = ST_WR_RESP;
            ST_WR_RESP: begin
                if (amba_master.b_valid) begin
                    resp_d  = resp_t'(amba_master.b_resp);
                    rdata_d = '0;
                    state_d = ST_RSP;
                end
            end
            ST_RD_ADDR: if (amba_master.ar_ready) state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                if (amba_master.r_valid) begin
                    resp_d  = resp_t'(amba_master.r_resp);
                    rdata_d = amba_master.r_data;
                    state_d = ST_RSP;
                end
            end
            ST_RSP:  if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            resp_q  <= OKAY;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
            resp_q  <= resp_d;
        end
    end

    // One-hot state bits drive the handshake outputs directly, so every output is a flop.
    assign req_ready            = state_q[S_IDLE];
    assign rsp_valid            = state_q[S_RSP];
    assign rsp_write            = write_q;
    assign rsp_rdata            = rdata_q;
    assign rsp_resp             = resp_q;
    assign amba_master.aw_addr  = addr_q;
    assign amba_master.aw_valid = state_q[S_WR_ADDR];
    assign amba_master.w_data   = wdata_q;
    assign amba_master.w_valid  = state_q[S_WR_DATA];
    assign amba_master.b_ready  = state_q[S_WR_RESP];
    assign amba_master.ar_addr  = addr_q;
    assign amba_master.ar_valid = state_q[S_RD_ADDR];
    assign amba_master.r_ready  = state_q[S_RD_DATA];

`ifdef AXI_MASTER_TIMEOUT_EN
    logic busy;
    assign busy = !(state_q[S_IDLE] || state_q[S_RSP]);

    axi4_lite_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy_i   (busy),
        .restart_i(state_d != state_q),
        .timeout_o(timeout)
    );
`endif
endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master against a small behavioural AXI4-Lite slave.
module tb_axi4_lite_master;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
`ifdef AXI_MASTER_TIMEOUT_EN
    logic        timeout;
`endif

    int total = 0;
    int bad   = 0;

    AXI_BUS #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    axi4_lite_master #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .amba_master(bus)
`ifdef AXI_MASTER_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural slave: w_ready only after the AW handshake, B and R one cycle after their request.
    logic [31:0] mem [0:1023];
    logic        aw_en, ar_en, aw_got, b_vld, r_vld;
    logic [9:0]  wa_q;
    logic [31:0] r_dat;
    logic [1:0]  slv_resp, b_rs, r_rs;

    assign bus.aw_ready = aw_en && !aw_got;
    assign bus.w_ready  = aw_got && !b_vld;
    assign bus.b_valid  = b_vld;
    assign bus.b_resp   = b_rs;
    assign bus.ar_ready = ar_en && !r_vld;
    assign bus.r_valid  = r_vld;
    assign bus.r_data   = r_dat;
    assign bus.r_resp   = r_rs;

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_got <= 1'b0; b_vld <= 1'b0; r_vld <= 1'b0;
            wa_q <= '0; r_dat <= '0; b_rs <= '0; r_rs <= '0;
        end else begin
            if (bus.aw_valid && bus.aw_ready) begin aw_got <= 1'b1; wa_q <= bus.aw_addr; end
            if (bus.w_valid && bus.w_ready) begin
                mem[wa_q] <= bus.w_data; aw_got <= 1'b0; b_vld <= 1'b1; b_rs <= slv_resp;
            end
            if (b_vld && bus.b_ready) b_vld <= 1'b0;
            if (bus.ar_valid && bus.ar_ready) begin
                r_vld <= 1'b1; r_dat <= mem[bus.ar_addr]; r_rs <= slv_resp;
            end
            if (r_vld && bus.r_ready) r_vld <= 1'b0;
        end
    end

    // Issues one request at a negedge; lat is the cycle (request accepted in cycle 0) of rsp_valid, -1 if none.
    task automatic do_req(input logic wr, input logic [9:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic [1:0] rs, output logic rw);
        int n;
        lat = -1; rd = 'x; rs = 'x; rw = 'x; n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (rsp_valid) begin lat = c; rd = rsp_rdata; rs = rsp_resp; rw = rsp_write; break; end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; aw_en = 1'b1; ar_en = 1'b1; slv_resp = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({req_ready, bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready, rsp_valid} !== 7'b1000000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=%b", {req_ready, bus.aw_valid, bus.w_valid, bus.b_ready,
                     bus.ar_valid, bus.r_ready, rsp_valid}, 7'b1000000);
        end
        total++;
        if ({rsp_write, rsp_rdata, rsp_resp, bus.aw_addr, bus.ar_addr, bus.w_data} !== 87'd0) begin
            bad++;
            $display("FAIL reset_data got rdata=%h resp=%h aw_addr=%h w_data=%h exp all 0",
                     rsp_rdata, rsp_resp, bus.aw_addr, bus.w_data);
        end
`ifdef AXI_MASTER_TIMEOUT_EN
        total++;
        if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic [1:0] rs; logic rw;
        do_req(1'b1, 10'h004, 32'h0000_00AB, lat, rd, rs, rw);
        total++;
        if (lat !== 4 || rs !== 2'b00 || rd !== 32'h0 || rw !== 1'b1) begin
            bad++; $display("FAIL write_basic got lat=%0d resp=%h rdata=%h write=%b exp lat=4 resp=0 rdata=0 write=1", lat, rs, rd, rw);
        end
        do_req(1'b0, 10'h004, 32'hFFFF_FFFF, lat, rd, rs, rw);
        total++;
        if (lat !== 3 || rs !== 2'b00 || rd !== 32'h0000_00AB || rw !== 1'b0) begin
            bad++; $display("FAIL read_basic got lat=%0d resp=%h rdata=%h write=%b exp lat=3 resp=0 rdata=000000ab write=0", lat, rs, rd, rw);
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2, lat; logic [31:0] rd; logic [1:0] rs; logic rw;
        logic rr_hist [0:31];
        c1 = -1; c2 = -1;
        for (int i = 0; i < 32; i++) rr_hist[i] = 1'bx;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h001; req_wdata = 32'h11; rsp_ready = 1'b1;
        @(negedge clk);
        req_addr = 10'h002; req_wdata = 32'h22;
        for (int c = 1; c <= 30; c++) begin
            rr_hist[c] = req_ready;
            if (rsp_valid) begin
                if (c1 < 0) c1 = c;
                else begin c2 = c; break; end
            end
            if (c1 > 0 && c == c1 + 2) req_valid = 1'b0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (c1 !== 4 || c2 !== 9) begin
            bad++; $display("FAIL b2b_latency got first=%0d second=%0d exp first=4 second=9", c1, c2);
        end
        total++;
        if (rr_hist[4] !== 1'b0 || rr_hist[5] !== 1'b1) begin
            bad++; $display("FAIL b2b_req_ready got c4=%b c5=%b exp c4=0 c5=1", rr_hist[4], rr_hist[5]);
        end
        do_req(1'b0, 10'h001, 32'h0, lat, rd, rs, rw);
        total++;
        if (rd !== 32'h11 || lat !== 3) begin bad++; $display("FAIL b2b_read1 got rdata=%h lat=%0d exp 00000011 lat=3", rd, lat); end
        do_req(1'b0, 10'h002, 32'h0, lat, rd, rs, rw);
        total++;
        if (rd !== 32'h22 || lat !== 3) begin bad++; $display("FAIL b2b_read2 got rdata=%h lat=%0d exp 00000022 lat=3", rd, lat); end
    endtask

    task automatic test_aw_stall();
        int errs, lat;
        errs = 0; lat = -1;
        aw_en = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h020; req_wdata = 32'h77; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (bus.aw_valid !== 1'b1 || bus.aw_addr !== 10'h020 || bus.w_valid !== 1'b0) errs++;
            if (c == 6) aw_en = 1'b1;
            @(negedge clk);
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL aw_stall_hold got %0d bad cycles exp 0", errs); end
        total++;
        if (bus.w_valid !== 1'b1 || bus.aw_valid !== 1'b0) begin
            bad++; $display("FAIL aw_stall_wphase got w_valid=%b aw_valid=%b exp 1 0", bus.w_valid, bus.aw_valid);
        end
        for (int c = 7; c <= 30; c++) begin
            if (rsp_valid) begin lat = c; break; end
            @(negedge clk);
        end
        @(negedge clk);
        total++;
        if (lat !== 9) begin bad++; $display("FAIL aw_stall_latency got=%0d exp=9", lat); end
    endtask

    task automatic test_rsp_backpressure();
        int lat, errs; logic [31:0] rd; logic [1:0] rs; logic rw;
        errs = 0;
        do_req(1'b1, 10'h3FF, 32'hCAFE_F00D, lat, rd, rs, rw);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL bp_write got lat=%0d exp 4", lat); end
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h3FF;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (rsp_valid !== (c >= 3) || req_ready !== 1'b0) errs++;
            if (c >= 3 && rsp_rdata !== 32'hCAFE_F00D) errs++;
            if (c == 6) rsp_ready = 1'b1;
            @(negedge clk);
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL bp_hold got %0d bad cycles exp 0", errs); end
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got rsp_valid=%b req_ready=%b exp 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic [1:0] rs; logic rw;
        do_req(1'b1, 10'h010, 32'h55, lat, rd, rs, rw);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h010; req_wdata = 32'h99; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.w_valid !== 1'b1) begin bad++; $display("FAIL rstmid_in_wdata got w_valid=%b exp 1", bus.w_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({req_ready, bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready, rsp_valid} !== 7'b1000000) begin
            bad++;
            $display("FAIL rstmid_ctrl got=%b exp=%b", {req_ready, bus.aw_valid, bus.w_valid, bus.b_ready,
                     bus.ar_valid, bus.r_ready, rsp_valid}, 7'b1000000);
        end
        rst_n = 1'b1;
        @(negedge clk);
        do_req(1'b0, 10'h010, 32'h0, lat, rd, rs, rw);
        total++;
        if (rd !== 32'h55 || lat !== 3) begin bad++; $display("FAIL rstmid_readback got rdata=%h lat=%0d exp 00000055 lat=3", rd, lat); end
    endtask

    task automatic test_err_resp();
        int lat; logic [31:0] rd; logic [1:0] rs; logic rw;
        slv_resp = 2'b10;
        do_req(1'b1, 10'h030, 32'h1, lat, rd, rs, rw);
        total++;
        if (rs !== 2'b10 || lat !== 4) begin bad++; $display("FAIL err_write got resp=%h lat=%0d exp 2 lat=4", rs, lat); end
        slv_resp = 2'b11;
        do_req(1'b0, 10'h030, 32'h0, lat, rd, rs, rw);
        total++;
        if (rs !== 2'b11 || rd !== 32'h1) begin bad++; $display("FAIL err_read got resp=%h rdata=%h exp 3 00000001", rs, rd); end
        slv_resp = 2'b00;
    endtask

`ifdef AXI_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int lat; logic t8, t9, av9;
        lat = -1; t8 = 1'bx; t9 = 1'bx; av9 = 1'bx;
        total++;
        if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_initial got=%b exp=0", timeout); end
        ar_en = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h004; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 8) t8 = timeout;
            if (c == 9) begin t9 = timeout; av9 = bus.ar_valid; ar_en = 1'b1; end
            @(negedge clk);
        end
        total++;
        if (t8 !== 1'b0 || t9 !== 1'b1 || av9 !== 1'b1) begin
            bad++; $display("FAIL tmo_trigger got c8=%b c9=%b ar_valid=%b exp 0 1 1", t8, t9, av9);
        end
        for (int c = 10; c <= 30; c++) begin
            if (rsp_valid) begin lat = c; break; end
            @(negedge clk);
        end
        @(negedge clk);
        total++;
        if (lat !== 11 || timeout !== 1'b1 || req_ready !== 1'b1) begin
            bad++; $display("FAIL tmo_sticky got lat=%0d timeout=%b req_ready=%b exp 11 1 1", lat, timeout, req_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_aw_stall();
        test_rsp_backpressure();
        test_reset_mid();
        test_err_resp();
`ifdef AXI_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end
endmodule
